// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: oversampled majority-vote bit recovery, optional parity,
// one or two stop bits, break wait, and a valid/ready holding register with overrun flag.
module uart_rx_cfg #(
  parameter int CLK_FREQ   = 25000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_par_err,
  output logic       rx_frm_err,
  output logic       rx_overrun,
  input  logic       ovr_clear,
  output logic       rx_busy
);

  // Rounded phase increment: floor((2*num + den) / (2*den)).
  localparam logic [63:0] INC_NUM = 64'(BAUD) * 64'(OVERSAMPLE) * 64'd131072 + 64'(CLK_FREQ);
  localparam logic [63:0] INC_DEN = 64'(CLK_FREQ) * 64'd2;
  localparam logic [63:0] INC_64  = INC_NUM / INC_DEN;
  localparam logic [15:0] INC     = INC_64[15:0];

  localparam int            CW       = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] MID_A    = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] MID_B    = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] MID_C    = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP1,
    S_STOP2,
    S_BRK
  } state_t;

  state_t        state_reg, state_next;
  logic          rxd_meta_reg, rxd_sync_reg;
  logic [1:0]    fill_reg;
  logic          armed_reg;
  logic [15:0]   acc_reg, acc_sum;
  logic          tick;
  logic [CW-1:0] cnt_reg;
  logic [1:0]    smp_reg;
  logic          maj, mid, finish;
  logic [2:0]    bit_reg;
  logic [7:0]    shift_reg;
  logic          par_err_reg, frm_err_reg, done_reg;
  logic [7:0]    hold_data_reg;
  logic          hold_par_reg, hold_frm_reg, valid_reg, ovr_reg;

  assign {tick, acc_sum} = {1'b0, acc_reg} + {1'b0, INC};
  assign maj = (smp_reg[0] & smp_reg[1]) | (smp_reg[0] & rxd_sync_reg) | (smp_reg[1] & rxd_sync_reg);
  assign mid = tick && (cnt_reg == MID_C);

  always_comb begin
    state_next = state_reg;
    finish     = 1'b0;
    case (state_reg)
      // armed_reg blocks a start on a line that has been low since reset
      S_IDLE:  if (armed_reg && !rxd_sync_reg) state_next = S_START;
      S_START: if (mid) state_next = maj ? S_IDLE : S_DATA;
      S_DATA:  if (mid && bit_reg == LAST_BIT) state_next = (PARITY != 0) ? S_PAR : S_STOP1;
      S_PAR:   if (mid) state_next = S_STOP1;
      S_STOP1: begin
        if (mid) begin
          if (STOP_BITS == 2) begin
            state_next = S_STOP2;
          end else begin
            finish     = 1'b1;
            state_next = maj ? S_IDLE : S_BRK;
          end
        end
      end
      S_STOP2: begin
        if (mid) begin
          finish     = 1'b1;
          state_next = maj ? S_IDLE : S_BRK;
        end
      end
      S_BRK:   if (rxd_sync_reg) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      rxd_meta_reg  <= 1'b1;
      rxd_sync_reg  <= 1'b1;
      fill_reg      <= 2'b00;
      armed_reg     <= 1'b0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      smp_reg       <= 2'b11;
      bit_reg       <= '0;
      shift_reg     <= '0;
      par_err_reg   <= 1'b0;
      frm_err_reg   <= 1'b0;
      done_reg      <= 1'b0;
      hold_data_reg <= '0;
      hold_par_reg  <= 1'b0;
      hold_frm_reg  <= 1'b0;
      valid_reg     <= 1'b0;
      ovr_reg       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rxd_meta_reg <= RxD;
      rxd_sync_reg <= rxd_meta_reg;
      fill_reg     <= {fill_reg[0], 1'b1};
      if (fill_reg[1] && rxd_sync_reg) armed_reg <= 1'b1;
      acc_reg <= acc_sum;

      if (state_reg == S_IDLE) cnt_reg <= '0;
      else if (tick)           cnt_reg <= cnt_reg + CW'(1);

      if (tick && (cnt_reg == MID_A || cnt_reg == MID_B)) smp_reg <= {smp_reg[0], rxd_sync_reg};

      if (state_reg == S_IDLE) begin
        bit_reg     <= '0;
        shift_reg   <= '0;
        par_err_reg <= 1'b0;
        frm_err_reg <= 1'b0;
      end
      if (mid && state_reg == S_DATA) begin
        shift_reg <= (shift_reg >> 1) | (8'(maj) << (DATA_BITS - 1));
        bit_reg   <= bit_reg + 3'd1;
      end
      if (mid && state_reg == S_PAR)
        par_err_reg <= ((^shift_reg) ^ maj) != (PARITY == 2);
      if (mid && (state_reg == S_STOP1 || state_reg == S_STOP2) && !maj)
        frm_err_reg <= 1'b1;
      done_reg <= finish;

      // A slot frees up in the same cycle it is accepted, so a coincident completion loads.
      if (done_reg && (!valid_reg || rx_ready)) begin
        hold_data_reg <= shift_reg;
        hold_par_reg  <= par_err_reg;
        hold_frm_reg  <= frm_err_reg;
        valid_reg     <= 1'b1;
      end else if (valid_reg && rx_ready) begin
        valid_reg <= 1'b0;
      end

      if (done_reg && valid_reg && !rx_ready) ovr_reg <= 1'b1;
      else if (ovr_clear)                     ovr_reg <= 1'b0;
    end
  end

  assign rx_data    = hold_data_reg;
  assign rx_valid   = valid_reg;
  assign rx_par_err = hold_par_reg;
  assign rx_frm_err = hold_frm_reg;
  assign rx_overrun = ovr_reg;
  assign rx_busy    = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: four instances (8N1, 7E1, 7O1, 8N2) at 32 clk per bit,
// each feature exercised by its own task with inline hand-computed expectations.
module tb_uart_rx_cfg;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      rxd;
  logic [3:0]      ready;
  logic [3:0]      ovr_clr;
  logic [3:0][7:0] data;
  logic [3:0]      valid, par, frm, ovr, busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLK_FREQ(3200000), .BAUD(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16)) u_8n1 (
    .clk(clk), .rst(rst), .RxD(rxd[0]), .rx_data(data[0]), .rx_valid(valid[0]), .rx_ready(ready[0]),
    .rx_par_err(par[0]), .rx_frm_err(frm[0]), .rx_overrun(ovr[0]), .ovr_clear(ovr_clr[0]), .rx_busy(busy[0]));
  uart_rx_cfg #(.CLK_FREQ(3200000), .BAUD(100000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .OVERSAMPLE(16)) u_7e1 (
    .clk(clk), .rst(rst), .RxD(rxd[1]), .rx_data(data[1]), .rx_valid(valid[1]), .rx_ready(ready[1]),
    .rx_par_err(par[1]), .rx_frm_err(frm[1]), .rx_overrun(ovr[1]), .ovr_clear(ovr_clr[1]), .rx_busy(busy[1]));
  uart_rx_cfg #(.CLK_FREQ(3200000), .BAUD(100000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(16)) u_7o1 (
    .clk(clk), .rst(rst), .RxD(rxd[2]), .rx_data(data[2]), .rx_valid(valid[2]), .rx_ready(ready[2]),
    .rx_par_err(par[2]), .rx_frm_err(frm[2]), .rx_overrun(ovr[2]), .ovr_clear(ovr_clr[2]), .rx_busy(busy[2]));
  uart_rx_cfg #(.CLK_FREQ(3200000), .BAUD(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .OVERSAMPLE(16)) u_8n2 (
    .clk(clk), .rst(rst), .RxD(rxd[3]), .rx_data(data[3]), .rx_valid(valid[3]), .rx_ready(ready[3]),
    .rx_par_err(par[3]), .rx_frm_err(frm[3]), .rx_overrun(ovr[3]), .ovr_clear(ovr_clr[3]), .rx_busy(busy[3]));

  // Frame bits LSB first (bit 0 = start); the line is left at the last bit driven.
  task automatic send_bits(input int ch, input logic [15:0] bits, input int nbits, input int bclk);
    for (int i = 0; i < nbits; i++) begin
      rxd[ch] = bits[i];
      repeat (bclk) @(negedge clk);
    end
  endtask

  task automatic wait_valid(input int ch, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      if (valid[ch]) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  // Returns at the first negedge where busy is low after having been high.
  task automatic wait_busy_fall(input int ch, input int limit, output bit ok);
    bit seen;
    seen = 1'b0;
    ok   = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      if (busy[ch]) seen = 1'b1;
      else if (seen) ok = 1'b1;
    end
  endtask

  task automatic accept(input int ch);
    ready[ch] = 1'b1;
    @(negedge clk);
    ready[ch] = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; rxd = '1; ready = '0; ovr_clr = '0;
    repeat (4) @(negedge clk);
    n_checks++; if (valid[0] !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid[0]); end
    n_checks++; if (data[0] !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", data[0]); end
    n_checks++; if (par[0] !== 1'b0) begin n_fail++; $display("FAIL reset_par: got %b expected 0", par[0]); end
    n_checks++; if (frm[0] !== 1'b0) begin n_fail++; $display("FAIL reset_frm: got %b expected 0", frm[0]); end
    n_checks++; if (ovr[0] !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b expected 0", ovr[0]); end
    n_checks++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy[0]); end
    rst = 1'b0;
    repeat (40) @(negedge clk);
    $display("reset done");
  endtask

  task automatic test_basic;
    bit ok;
    logic v0, v1;
    v0 = 1'bx; v1 = 1'bx;
    fork
      send_bits(0, 16'({1'b1, 8'hA5, 1'b0}), 10, 32);
      begin
        wait_busy_fall(0, 400, ok);
        v0 = valid[0];
        @(negedge clk);
        v1 = valid[0];
      end
    join
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_frame_end: got no busy fall, expected one"); end
    n_checks++; if (v0 !== 1'b0) begin n_fail++; $display("FAIL basic_valid_at_stop: got %b expected 0", v0); end
    n_checks++; if (v1 !== 1'b1) begin n_fail++; $display("FAIL basic_valid_next_clk: got %b expected 1", v1); end
    n_checks++; if (data[0] !== 8'hA5) begin n_fail++; $display("FAIL basic_data: got %h expected a5", data[0]); end
    n_checks++; if (par[0] !== 1'b0) begin n_fail++; $display("FAIL basic_par: got %b expected 0", par[0]); end
    n_checks++; if (frm[0] !== 1'b0) begin n_fail++; $display("FAIL basic_frm: got %b expected 0", frm[0]); end
    repeat (100) @(negedge clk);
    n_checks++; if ({valid[0], data[0]} !== {1'b1, 8'hA5}) begin n_fail++; $display("FAIL basic_hold: got v=%b d=%h expected v=1 d=a5", valid[0], data[0]); end
    accept(0);
    n_checks++; if (valid[0] !== 1'b0) begin n_fail++; $display("FAIL basic_drop: got %b expected 0", valid[0]); end
    $display("8N1 rx data=%h", 8'hA5);
  endtask

  task automatic test_parity;
    bit ok;
    // 0x41 has two ones: even parity bit 0, odd parity bit 1. 0x43 has three ones.
    send_bits(1, 16'({1'b1, 1'b1, 7'h41, 1'b0}), 10, 32);
    wait_valid(1, 100, ok);
    n_checks++; if ({ok, data[1], par[1], frm[1]} !== {1'b1, 8'h41, 1'b1, 1'b0}) begin n_fail++; $display("FAIL par_7e1_bad: got ok=%b d=%h p=%b f=%b expected ok=1 d=41 p=1 f=0", ok, data[1], par[1], frm[1]); end
    accept(1);
    $display("7E1 rx data=%h wrong parity", 8'h41);
    send_bits(1, 16'({1'b1, 1'b1, 7'h43, 1'b0}), 10, 32);
    wait_valid(1, 100, ok);
    n_checks++; if ({ok, data[1], par[1], frm[1]} !== {1'b1, 8'h43, 1'b0, 1'b0}) begin n_fail++; $display("FAIL par_7e1_good: got ok=%b d=%h p=%b f=%b expected ok=1 d=43 p=0 f=0", ok, data[1], par[1], frm[1]); end
    accept(1);
    $display("7E1 rx data=%h good parity", 8'h43);
    send_bits(2, 16'({1'b1, 1'b1, 7'h41, 1'b0}), 10, 32);
    wait_valid(2, 100, ok);
    n_checks++; if ({ok, data[2], par[2], frm[2]} !== {1'b1, 8'h41, 1'b0, 1'b0}) begin n_fail++; $display("FAIL par_7o1_good: got ok=%b d=%h p=%b f=%b expected ok=1 d=41 p=0 f=0", ok, data[2], par[2], frm[2]); end
    accept(2);
    $display("7O1 rx data=%h good parity", 8'h41);
    send_bits(2, 16'({1'b1, 1'b0, 7'h41, 1'b0}), 10, 32);
    wait_valid(2, 100, ok);
    n_checks++; if ({ok, data[2], par[2]} !== {1'b1, 8'h41, 1'b1}) begin n_fail++; $display("FAIL par_7o1_bad: got ok=%b d=%h p=%b expected ok=1 d=41 p=1", ok, data[2], par[2]); end
    accept(2);
    n_checks++; if (valid[2] !== 1'b0) begin n_fail++; $display("FAIL par_7o1_drop: got %b expected 0", valid[2]); end
    $display("7O1 rx data=%h wrong parity", 8'h41);
  endtask

  task automatic test_break;
    bit ok;
    send_bits(3, 16'({1'b0, 1'b1, 8'h3C, 1'b0}), 11, 32);
    wait_valid(3, 100, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL brk_valid: got none expected rx_valid"); end
    n_checks++; if ({data[3], frm[3], par[3]} !== {8'h3C, 1'b1, 1'b0}) begin n_fail++; $display("FAIL brk_word: got d=%h f=%b p=%b expected d=3c f=1 p=0", data[3], frm[3], par[3]); end
    repeat (4 * 32 - 8) @(negedge clk);
    n_checks++; if (busy[3] !== 1'b1) begin n_fail++; $display("FAIL brk_busy_low_line: got %b expected 1", busy[3]); end
    rxd[3] = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++; if (busy[3] !== 1'b0) begin n_fail++; $display("FAIL brk_busy_after_high: got %b expected 0", busy[3]); end
    accept(3);
    repeat (40) @(negedge clk);
    n_checks++; if ({valid[3], busy[3]} !== 2'b00) begin n_fail++; $display("FAIL brk_quiet: got v=%b b=%b expected 00", valid[3], busy[3]); end
    $display("8N2 rx data=%h framing error", 8'h3C);
  endtask

  task automatic test_glitch;
    bit saw_busy, any_valid;
    saw_busy = 1'b0; any_valid = 1'b0;
    rxd[0] = 1'b0;
    repeat (6) @(negedge clk);
    rxd[0] = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy[0]) saw_busy = 1'b1;
    end
    n_checks++; if (saw_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_start_seen: got %b expected 1", saw_busy); end
    n_checks++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL glitch_back_idle: got %b expected 0", busy[0]); end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (valid[0]) any_valid = 1'b1;
    end
    n_checks++; if (any_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_no_word: got %b expected 0", any_valid); end
    $display("glitch rejected");
  endtask

  task automatic test_overrun;
    bit ok;
    send_bits(0, 16'({1'b1, 8'h11, 1'b0}), 10, 32);
    wait_valid(0, 100, ok);
    n_checks++; if ({ok, data[0]} !== {1'b1, 8'h11}) begin n_fail++; $display("FAIL ovr_first: got ok=%b d=%h expected ok=1 d=11", ok, data[0]); end
    n_checks++; if (ovr[0] !== 1'b0) begin n_fail++; $display("FAIL ovr_not_yet: got %b expected 0", ovr[0]); end
    send_bits(0, 16'({1'b1, 8'h22, 1'b0}), 10, 32);
    repeat (8) @(negedge clk);
    n_checks++; if ({valid[0], data[0]} !== {1'b1, 8'h11}) begin n_fail++; $display("FAIL ovr_old_kept: got v=%b d=%h expected v=1 d=11", valid[0], data[0]); end
    n_checks++; if (ovr[0] !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b expected 1", ovr[0]); end
    ovr_clr[0] = 1'b1;
    @(negedge clk);
    ovr_clr[0] = 1'b0;
    n_checks++; if (ovr[0] !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b expected 0", ovr[0]); end
    accept(0);
    n_checks++; if (valid[0] !== 1'b0) begin n_fail++; $display("FAIL ovr_drop: got %b expected 0", valid[0]); end
    $display("overrun rx data=%h dropped=%h", 8'h11, 8'h22);
  endtask

  task automatic test_back_to_back;
    bit ok, fell;
    send_bits(0, 16'({1'b1, 8'h33, 1'b0}), 10, 32);
    wait_valid(0, 100, ok);
    n_checks++; if ({ok, data[0]} !== {1'b1, 8'h33}) begin n_fail++; $display("FAIL b2b_first: got ok=%b d=%h expected ok=1 d=33", ok, data[0]); end
    fork
      send_bits(0, 16'({1'b1, 8'h44, 1'b0}), 10, 32);
      begin
        wait_busy_fall(0, 400, fell);
        accept(0);
      end
    join
    n_checks++; if (fell !== 1'b1) begin n_fail++; $display("FAIL b2b_frame_end: got no busy fall, expected one"); end
    n_checks++; if ({valid[0], data[0]} !== {1'b1, 8'h44}) begin n_fail++; $display("FAIL b2b_new_word: got v=%b d=%h expected v=1 d=44", valid[0], data[0]); end
    n_checks++; if (ovr[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_no_ovr: got %b expected 0", ovr[0]); end
    accept(0);
    n_checks++; if (valid[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_drop: got %b expected 0", valid[0]); end
    $display("back-to-back rx data=%h then %h", 8'h33, 8'h44);
  endtask

  task automatic test_reset_mid;
    bit ok;
    send_bits(0, 16'({1'b1, 8'h11, 1'b0}), 10, 32);
    wait_valid(0, 100, ok);
    // Line goes low as a frame of all zeros and stays low across the reset.
    rxd[0] = 1'b0;
    repeat (3 * 32 + 16) @(negedge clk);
    n_checks++; if ({valid[0], busy[0]} !== 2'b11) begin n_fail++; $display("FAIL rstmid_before: got v=%b b=%b expected 11", valid[0], busy[0]); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if ({valid[0], busy[0]} !== 2'b00) begin n_fail++; $display("FAIL rstmid_cleared: got v=%b b=%b expected 00", valid[0], busy[0]); end
    repeat (5 * 32) @(negedge clk);
    n_checks++; if ({valid[0], busy[0]} !== 2'b00) begin n_fail++; $display("FAIL rstmid_no_restart: got v=%b b=%b expected 00", valid[0], busy[0]); end
    rxd[0] = 1'b1;
    repeat (64) @(negedge clk);
    send_bits(0, 16'({1'b1, 8'h5A, 1'b0}), 10, 32);
    wait_valid(0, 100, ok);
    n_checks++; if ({ok, data[0], frm[0], par[0]} !== {1'b1, 8'h5A, 1'b0, 1'b0}) begin n_fail++; $display("FAIL rstmid_word: got ok=%b d=%h f=%b p=%b expected ok=1 d=5a f=0 p=0", ok, data[0], frm[0], par[0]); end
    accept(0);
    $display("reset mid-frame, rx data=%h", 8'h5A);
  endtask

  task automatic test_baud_sweep;
    bit ok;
    send_bits(0, 16'({1'b1, 8'h96, 1'b0}), 10, 31);
    wait_valid(0, 100, ok);
    n_checks++; if ({ok, data[0], frm[0], par[0]} !== {1'b1, 8'h96, 1'b0, 1'b0}) begin n_fail++; $display("FAIL baud_fast: got ok=%b d=%h f=%b p=%b expected ok=1 d=96 f=0 p=0", ok, data[0], frm[0], par[0]); end
    accept(0);
    $display("baud +3%% rx data=%h", 8'h96);
    send_bits(0, 16'({1'b1, 8'h69, 1'b0}), 10, 33);
    wait_valid(0, 100, ok);
    n_checks++; if ({ok, data[0], frm[0], par[0]} !== {1'b1, 8'h69, 1'b0, 1'b0}) begin n_fail++; $display("FAIL baud_slow: got ok=%b d=%h f=%b p=%b expected ok=1 d=69 f=0 p=0", ok, data[0], frm[0], par[0]); end
    accept(0);
    $display("baud -3%% rx data=%h", 8'h69);
    send_bits(1, 16'({1'b1, 1'b0, 7'h55, 1'b0}), 10, 33);
    wait_valid(1, 100, ok);
    n_checks++; if ({ok, data[1], frm[1], par[1]} !== {1'b1, 8'h55, 1'b0, 1'b0}) begin n_fail++; $display("FAIL baud_slow_7e1: got ok=%b d=%h f=%b p=%b expected ok=1 d=55 f=0 p=0", ok, data[1], frm[1], par[1]); end
    accept(1);
    $display("7E1 baud -3%% rx data=%h", 8'h55);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_parity;
    test_break;
    test_glitch;
    test_overrun;
    test_back_to_back;
    test_reset_mid;
    test_baud_sweep;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule
